// File: rtl/cswap_pkg.sv
// Shared definitions for the controlled-swap sort sequencer: FSM encoding,
// swap counter width and the fixed RUN-cycle count for a given bank depth.
package cswap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SWAP_CNT_W = 16;

  // Full-length sort: N/2 even phases of N/2 pairs plus N/2 odd phases of N/2-1 pairs.
  function automatic int run_cycles(input int n);
    return (n / 2) * (n / 2) + (n / 2) * (n / 2 - 1);
  endfunction

endpackage

// File: rtl/cswap_lane.sv
// W-bit Fredkin lane: ctl passes through, b/c exchange when ctl is set.
module cswap_lane #(
  parameter int W = 8
) (
  input  logic         ctl,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic         ctl_o,
  output logic [W-1:0] b_o,
  output logic [W-1:0] c_o
);

  assign ctl_o = ctl;
  assign b_o   = (b & ~{W{ctl}}) | (c & {W{ctl}});
  assign c_o   = (c & ~{W{ctl}}) | (b & {W{ctl}});

endmodule

// File: rtl/cswap_sort_ctrl.sv
// Odd-even transposition sort over an N-entry bank through one shared cswap lane.
// Optional early exit on a swap-free even/odd phase pair: define CSWAP_EARLY_EXIT_EN.
//
// state | meaning
// IDLE  | bank loadable, waiting for start
// RUN   | one adjacent pair compared/swapped per cycle
// DONE  | one-cycle done pulse, bank loadable
module cswap_sort_ctrl
  import cswap_pkg::*;
#(
  parameter int W  = 8,
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  load_en,
  input  logic [IW-1:0]         load_idx,
  input  logic [W-1:0]          load_data,
  input  logic [IW-1:0]         rd_idx,
  output logic [W-1:0]          rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [SWAP_CNT_W-1:0] swap_count
);

  if ((N < 2) || (N % 2 != 0)) begin : g_bad_n
    $error("cswap_sort_ctrl: N must be even and >= 2");
  end

  localparam logic [IW-1:0] LAST_EVEN  = IW'(N / 2 - 1);
  localparam logic [IW-1:0] LAST_ODD   = IW'(N / 2 - 2);
  // N=2 has an empty odd phase, so the single even phase finishes the sort.
  localparam logic [IW-1:0] LAST_PHASE = (N == 2) ? '0 : IW'(N - 1);

  state_t                  state_q, state_d;
  logic [IW-1:0]           phase_q, phase_d;
  logic [IW-1:0]           pair_q, pair_d;
  logic [W-1:0]            bank_q [N];
  logic [W-1:0]            bank_d [N];
  logic [SWAP_CNT_W-1:0]   swap_cnt_q, swap_cnt_d;
  logic [W-1:0]            rd_data_q;

  logic [IW-1:0]           lo_idx, hi_idx, last_pair;
  logic [W-1:0]            lane_b, lane_c;
  logic                    swap;

  assign lo_idx    = (pair_q << 1) | IW'(phase_q[0]);
  assign hi_idx    = lo_idx + IW'(1);
  assign last_pair = phase_q[0] ? LAST_ODD : LAST_EVEN;

  cswap_lane #(.W(W)) u_lane (
    .ctl   (bank_q[lo_idx] > bank_q[hi_idx]),
    .b     (bank_q[lo_idx]),
    .c     (bank_q[hi_idx]),
    .ctl_o (swap),
    .b_o   (lane_b),
    .c_o   (lane_c)
  );

`ifdef CSWAP_EARLY_EXIT_EN
  logic flag_q, flag_d;

  always_comb begin
    flag_d = 1'b0;
    if (state_q == RUN) begin
      flag_d = (!phase_q[0] && (pair_q == '0)) ? swap : (flag_q | swap);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flag_q <= 1'b0;
    else       flag_q <= flag_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      pair_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pair_q  <= pair_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pair_d  = pair_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          phase_d = '0;
          pair_d  = '0;
        end
      end
      RUN: begin
        if (pair_q == last_pair) begin
          pair_d  = '0;
          phase_d = phase_q + IW'(1);
          if (phase_q == LAST_PHASE) state_d = DONE;
`ifdef CSWAP_EARLY_EXIT_EN
          if (phase_q[0] && !(flag_q || swap)) state_d = DONE;
`endif
        end else begin
          pair_d = pair_q + IW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Load lands before the first RUN read, so a same-edge load/start is sorted.
  always_comb begin
    bank_d     = bank_q;
    swap_cnt_d = swap_cnt_q;
    if ((state_q != RUN) && load_en) bank_d[load_idx] = load_data;
    if ((state_q == IDLE) && start) swap_cnt_d = '0;
    if (state_q == RUN) begin
      bank_d[lo_idx] = lane_b;
      bank_d[hi_idx] = lane_c;
      if (swap && (swap_cnt_q != '1)) swap_cnt_d = swap_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q     <= '{default: '0};
      swap_cnt_q <= '0;
      rd_data_q  <= '0;
    end else begin
      bank_q     <= bank_d;
      swap_cnt_q <= swap_cnt_d;
      rd_data_q  <= bank_q[rd_idx];
    end
  end

  assign rd_data    = rd_data_q;
  assign swap_count = swap_cnt_q;

endmodule

// File: tb/tb_cswap_sort_ctrl.sv
// Directed bench for cswap_sort_ctrl (N=8, W=8); honours CSWAP_EARLY_EXIT_EN for latency.
module tb_cswap_sort_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       load_en;
  logic [2:0] load_idx;
  logic [7:0] load_data;
  logic [2:0] rd_idx;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic [15:0] swap_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cswap_sort_ctrl #(.W(8), .N(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_en    (load_en),
    .load_idx   (load_idx),
    .load_data  (load_data),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .swap_count (swap_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_bank(input logic [7:0] v0, v1, v2, v3, v4, v5, v6, v7);
    logic [7:0] vals [8];
    vals = '{v0, v1, v2, v3, v4, v5, v6, v7};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_idx  = 3'(i);
      load_data = vals[i];
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic check_bank(input string tag, input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7);
    logic [7:0] exp [8];
    exp = '{e0, e1, e2, e3, e4, e5, e6, e7};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rd_idx = 3'(i);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s_rd%0d", tag, i), 32'(rd_data), 32'(exp[i]));
    end
  endtask

  // Start at edge k; lat = number of edges after k until done is first seen.
  task automatic run_sort(input bit abuse, input bit load_same, input logic [7:0] ld_val,
                          output int lat, output int pulses);
    @(negedge clk);
    start = 1'b1;
    if (load_same) begin
      load_en   = 1'b1;
      load_idx  = 3'd0;
      load_data = ld_val;
    end
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    load_en = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    lat    = -1;
    pulses = 0;
    for (int c = 1; c <= 60; c++) begin
      if (abuse && c == 5) begin
        start     = 1'b1;
        load_en   = 1'b1;
        load_idx  = 3'd3;
        load_data = 8'hAA;
      end
      if (abuse && c == 6) begin
        start   = 1'b0;
        load_en = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        pulses++;
        if (lat < 0) lat = c;
      end
      if (c == 27) check("busy_before_last", 32'(busy), 32'd1);
    end
    check("busy_after_sort", 32'(busy), 32'd0);
  endtask

  int lat, pulses;

  initial begin
    reset = 1'b1; start = 1'b0; load_en = 1'b0;
    load_idx = '0; load_data = '0; rd_idx = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_swap_count", 32'(swap_count), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);

    // Reset in the middle of a sort
    load_bank(8, 7, 6, 5, 4, 3, 2, 1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("midrst_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #2;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    check_bank("midrst", 0, 0, 0, 0, 0, 0, 0, 0);

    // Reverse order
    load_bank(8, 7, 6, 5, 4, 3, 2, 1);
    run_sort(1'b0, 1'b0, 8'h00, lat, pulses);
`ifndef CSWAP_EARLY_EXIT_EN
    check("rev_latency", 32'(lat), 32'd28);
`endif
    check("rev_pulses", 32'(pulses), 32'd1);
    check("rev_swaps", 32'(swap_count), 32'd28);
    check_bank("rev", 1, 2, 3, 4, 5, 6, 7, 8);

    // Already sorted
    load_bank(1, 2, 3, 4, 5, 6, 7, 8);
    run_sort(1'b0, 1'b0, 8'h00, lat, pulses);
`ifdef CSWAP_EARLY_EXIT_EN
    check("sorted_latency", 32'(lat), 32'd7);
`else
    check("sorted_latency", 32'(lat), 32'd28);
`endif
    check("sorted_pulses", 32'(pulses), 32'd1);
    check("sorted_swaps", 32'(swap_count), 32'd0);
    check_bank("sorted", 1, 2, 3, 4, 5, 6, 7, 8);

    // Duplicates and extremes: 15 strict inversions
    load_bank(8'hFF, 8'h00, 8'h80, 8'h80, 8'h01, 8'hFF, 8'h00, 8'h7F);
    run_sort(1'b0, 1'b0, 8'h00, lat, pulses);
`ifndef CSWAP_EARLY_EXIT_EN
    check("dup_latency", 32'(lat), 32'd28);
`endif
    check("dup_swaps", 32'(swap_count), 32'd15);
    check_bank("dup", 8'h00, 8'h00, 8'h01, 8'h7F, 8'h80, 8'h80, 8'hFF, 8'hFF);

    // Start and load pulsed during RUN are ignored
    load_bank(8, 7, 6, 5, 4, 3, 2, 1);
    run_sort(1'b1, 1'b0, 8'h00, lat, pulses);
`ifndef CSWAP_EARLY_EXIT_EN
    check("abuse_latency", 32'(lat), 32'd28);
`endif
    check("abuse_pulses", 32'(pulses), 32'd1);
    check("abuse_swaps", 32'(swap_count), 32'd28);
    check_bank("abuse", 1, 2, 3, 4, 5, 6, 7, 8);

    // Load and start on the same IDLE edge: bank becomes 05,04,03,07,01,06,02,08
    load_bank(8'h09, 8'h04, 8'h03, 8'h07, 8'h01, 8'h06, 8'h02, 8'h08);
    run_sort(1'b0, 1'b1, 8'h05, lat, pulses);
    check("same_edge_pulses", 32'(pulses), 32'd1);
    check("same_edge_swaps", 32'(swap_count), 32'd13);
    check_bank("same_edge", 1, 2, 3, 4, 5, 6, 7, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cswap_sort_ctrl.md
Name: cswap_sort_ctrl

Overview:
- Sequencer that time-shares one W-bit controlled-swap (Fredkin) datapath across an N-entry register bank and runs an odd-even transposition sort, ascending and unsigned.
- Each busy cycle feeds one adjacent pair through the cswap lane. Control = (lo > hi); when control is 1 the two words are swapped.
- Sits between a host load/readback port and the cswap datapath. Provides a start/busy/done handshake.

Parameters:
- W, 8: data word width in bits.
- N, 8: number of bank entries. Must be even and ≥2.
- IW, $clog2(N): index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset. One clock; reset is asynchronous and active-high.
- start  in  1  request a sort. Sampled only in IDLE.
- load_en  in  1  write load_data into bank[load_idx]. Honoured in IDLE and DONE only.
- load_idx  in  IW  load address.
- load_data  in  W  load word.
- rd_idx  in  IW  readback address.
- rd_data  out  W  registered bank[rd_idx]; 1-cycle latency.
- busy  out  1  high while a sort is in progress.
- done  out  1  one-cycle pulse after the sort completes.
- swap_count  out  16  number of swaps in the last sort. Saturates at 16'hFFFF.

Behaviour:
- Reset values: bank all 0, rd_data=0, busy=0, done=0, swap_count=0, state=IDLE, phase=0, pair=0.
- Reset asserted mid-sort: return to IDLE immediately. Bank contents are cleared; no done pulse is produced.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE, start=1 at edge k: go to RUN, set busy=1, phase=0, pair=0, clear swap_count. If load_en is also high at edge k, the load is performed first, then the sort starts.
  - RUN: one pair per cycle.
    - Even phase: pairs (0,1),(2,3)…(N-2,N-1); N/2 pairs.
    - Odd phase: pairs (1,2)…(N-3,N-2); N/2-1 pairs.
    - Pair index p maps to lo = 2p + (phase odd). Stop at the last pair of the phase, then advance the phase.
  - RUN, after the last pair of phase N-1: go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle, then IDLE.
- Latency: total RUN cycles = (N/2)² + (N/2)(N/2-1). For N=8 this is 28.
  - With start at edge k: the last write happens at edge k+28, done is high in the cycle after edge k+28, and busy is high from edge k to edge k+28.
- Each RUN edge writes both bank entries from the cswap lane outputs. When control=1, swap_count increments by 1, saturating.
- Ignored inputs:
  - start while RUN or DONE is ignored and not queued.
  - load_en during RUN is ignored.
  - rd_idx during RUN returns the live, partially sorted contents.
- Equal values (lo == hi): no swap, no count.
- A value of N outside the allowed range must trip an elaboration-time check.

Optional Feature:
- Macro: CSWAP_EARLY_EXIT_EN.
- Defined:
  - A 1-bit flag records whether any swap occurred since the last even-phase start.
  - At the end of each odd phase, if the flag is 0, go straight to DONE.
  - An already-sorted bank with N=8 completes after 7 RUN cycles.
- Undefined: always runs all N phases (fixed latency). The flag logic is absent.

Decomposition:
- Shared package cswap_pkg contains:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - SWAP_CNT_W=16;
  - localparam function computing total RUN cycles from N.
- Sub-module cswap_lane: W-bit bitwise Fredkin lane with inputs ctl, b, c and outputs ctl_o, b_o, c_o.
  - ctl=0: b_o=b, c_o=c.
  - ctl=1: b_o=c, c_o=b.
  - Purely combinational; one instance only.
  - The controller drives ctl from the unsigned compare.

Test Plan:
1. Reset mid-sort: load 8,7,6,5,4,3,2,1 and start; assert reset at RUN cycle 10 → busy=0, done never pulses, all rd_data reads return 0.
2. Reverse order: load 8,7,6,5,4,3,2,1 and start → done exactly 29 cycles after the start edge, bank reads 1..8, swap_count=28.
3. Already sorted: load 1..8 with macro undefined → 28 RUN cycles, swap_count=0, bank unchanged. With CSWAP_EARLY_EXIT_EN → done after 7 RUN cycles.
4. Duplicates and extremes: load 0xFF,0x00,0x80,0x80,0x01,0xFF,0x00,0x7F → bank reads 00,00,01,7F,80,80,FF,FF. Equal pairs never counted.
5. Handshake abuse: pulse start and load_en(idx 3, 0xAA) during RUN → no restart, bank[3] not overwritten, single done pulse.
6. Load/start same edge in IDLE: load idx 0 = 0x05 onto bank 0x09,0x04,… with start high → sort includes 0x05. busy rises on that edge.
